// File: rtl/text_console_writer.sv
// text_console_writer: turns an ASCII byte stream into glyph writes for the
// text-mode screen buffer, with cursor tracking and row/screen clearing.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | waiting for a byte; char_ready=1
//   CLR_ROW | zero-filling the row the cursor just moved onto
//   CLR_ALL | zero-filling the whole screen after a form-feed
//
// A clear is driven by an address up-counter plus a down-counter of the
// writes still owed; the clear finishes when the down-counter reaches zero.
// The first cell of an LF/FF clear is written in the accept cycle itself.
// A wrapping printable instead spends that cycle on the character write,
// so its row clear starts one cycle later.
module text_console_writer #(
    parameter int CHAR_COLUMNS = 60,
    parameter int CHAR_ROWS    = 17,
    parameter int ADDR_W       = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        char_data,
    input  logic              char_valid,
    output logic              char_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [6:0]        wr_data,
    output logic [6:0]        cursor_x,
    output logic [4:0]        cursor_y
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLR_ROW = 2'd1,
        CLR_ALL = 2'd2
    } state_t;

    localparam int CNT_W = ADDR_W + 1;

    localparam logic [6:0]        LAST_COL  = 7'(CHAR_COLUMNS - 1);
    localparam logic [4:0]        LAST_ROW  = 5'(CHAR_ROWS - 1);
    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(CHAR_COLUMNS);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  ROW_CELLS = CNT_W'(CHAR_COLUMNS);
    localparam logic [CNT_W-1:0]  ALL_CELLS = CNT_W'(CHAR_COLUMNS * CHAR_ROWS);

    state_t            state;
    logic [ADDR_W-1:0] clr_addr;
    logic [CNT_W-1:0]  clr_left;

    logic [4:0]        next_row;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] next_base;
    logic              is_print;

    function automatic logic [ADDR_W-1:0] row_base(input logic [4:0] row);
        return ADDR_W'(row) * COLS_A;
    endfunction

    assign char_ready = (state == IDLE);

    // Cursor-derived addresses and the row a line advance would land on.
    always_comb begin
        next_row  = (cursor_y == LAST_ROW) ? 5'd0 : cursor_y + 5'd1;
        cur_addr  = row_base(cursor_y) + ADDR_W'(cursor_x);
        next_base = row_base(next_row);
        is_print  = (char_data >= 8'h20) && (char_data <= 8'h7E);
    end

    // Byte decode, cursor update and clear sequencing; all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= 7'd0;
            cursor_x <= 7'd0;
            cursor_y <= 5'd0;
            clr_addr <= '0;
            clr_left <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (char_valid) begin
                        if (is_print) begin
                            wr_en   <= 1'b1;
                            wr_addr <= cur_addr;
                            wr_data <= 7'(char_data - 8'h20);
                            if (cursor_x == LAST_COL) begin
                                cursor_x <= 7'd0;
                                cursor_y <= next_row;
                                clr_addr <= next_base;
                                clr_left <= ROW_CELLS;
                                state    <= CLR_ROW;
                            end else begin
                                cursor_x <= cursor_x + 7'd1;
                            end
                        end else begin
                            case (char_data)
                                8'h0A: begin
                                    cursor_x <= 7'd0;
                                    cursor_y <= next_row;
                                    wr_en    <= 1'b1;
                                    wr_addr  <= next_base;
                                    wr_data  <= 7'd0;
                                    clr_addr <= next_base + ADDR_ONE;
                                    clr_left <= ROW_CELLS - CNT_ONE;
                                    state    <= CLR_ROW;
                                end
                                8'h0D: begin
                                    cursor_x <= 7'd0;
                                end
                                8'h08: begin
                                    if (cursor_x != 7'd0) begin
                                        cursor_x <= cursor_x - 7'd1;
                                        wr_en    <= 1'b1;
                                        wr_addr  <= cur_addr - ADDR_ONE;
                                        wr_data  <= 7'd0;
                                    end
                                end
                                8'h0C: begin
                                    cursor_x <= 7'd0;
                                    cursor_y <= 5'd0;
                                    wr_en    <= 1'b1;
                                    wr_addr  <= '0;
                                    wr_data  <= 7'd0;
                                    clr_addr <= ADDR_ONE;
                                    clr_left <= ALL_CELLS - CNT_ONE;
                                    state    <= CLR_ALL;
                                end
                                default: begin
                                end
                            endcase
                        end
                    end
                end
                CLR_ROW, CLR_ALL: begin
                    if (clr_left == '0) begin
                        state <= IDLE;
                    end else begin
                        wr_en    <= 1'b1;
                        wr_addr  <= clr_addr;
                        wr_data  <= 7'd0;
                        clr_addr <= clr_addr + ADDR_ONE;
                        clr_left <= clr_left - CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer at the small 8x2 screen size.
module tb_text_console_writer;

    localparam int C  = 8;
    localparam int R  = 2;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    char_data;
    logic          char_valid;
    logic          char_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [6:0]    wr_data;
    logic [6:0]    cursor_x;
    logic [4:0]    cursor_y;

    text_console_writer #(
        .CHAR_COLUMNS(C),
        .CHAR_ROWS   (R),
        .ADDR_W      (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .char_data (char_data),
        .char_valid(char_valid),
        .char_ready(char_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cursor_x  (cursor_x),
        .cursor_y  (cursor_y)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic     en;
        int       addr;
        int       data;
        logic     rdy;
    } exp_t;

    exp_t q[$];
    int   mx;
    int   my;
    logic cur_rdy;
    int   errs;
    int   checks;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void push(input logic en, input int addr, input int data, input logic rdy);
        exp_t e;
        e.en   = en;
        e.addr = addr;
        e.data = data;
        e.rdy  = rdy;
        q.push_back(e);
    endfunction

    // Screen rules: expected per-cycle activity following an accepted byte.
    function automatic void model_accept(input logic [7:0] b);
        int v;
        v = int'(b);
        if (v >= 32 && v <= 126) begin
            if (mx == C - 1) begin
                push(1'b1, my * C + mx, v - 32, 1'b0);
                mx = 0;
                my = (my + 1) % R;
                for (int k = 0; k < C; k++) push(1'b1, my * C + k, 0, 1'b0);
            end else begin
                push(1'b1, my * C + mx, v - 32, 1'b1);
                mx = mx + 1;
            end
        end else if (v == 10) begin
            mx = 0;
            my = (my + 1) % R;
            for (int k = 0; k < C; k++) push(1'b1, my * C + k, 0, 1'b0);
        end else if (v == 13) begin
            mx = 0;
        end else if (v == 8) begin
            if (mx > 0) begin
                mx = mx - 1;
                push(1'b1, my * C + mx, 0, 1'b1);
            end
        end else if (v == 12) begin
            mx = 0;
            my = 0;
            for (int k = 0; k < C * R; k++) push(1'b1, k, 0, 1'b0);
        end
    endfunction

    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (q.size() > 0) begin
            e = q.pop_front();
        end else begin
            e.en = 1'b0; e.addr = 0; e.data = 0; e.rdy = 1'b1;
        end
        chk("wr_en", wr_en, e.en);
        if (e.en) begin
            chk("wr_addr", wr_addr, e.addr);
            chk("wr_data", wr_data, e.data);
        end
        chk("char_ready", char_ready, e.rdy);
        chk("cursor_x", cursor_x, mx);
        chk("cursor_y", cursor_y, my);
        cur_rdy = e.rdy;
    endtask

    task automatic send(input logic [7:0] b);
        bit done;
        done       = 1'b0;
        char_data  = b;
        char_valid = 1'b1;
        for (int g = 0; g < 200 && !done; g++) begin
            if (cur_rdy) begin
                model_accept(b);
                done = 1'b1;
            end
            tick();
        end
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
        char_valid = 1'b0;
    endtask

    function automatic logic [7:0] rand_byte();
        int r;
        logic [7:0] b;
        r = $urandom_range(0, 99);
        if (r < 70)      b = 8'($urandom_range(32, 126));
        else if (r < 78) b = 8'h0A;
        else if (r < 83) b = 8'h0D;
        else if (r < 91) b = 8'h08;
        else if (r < 93) b = 8'h0C;
        else if (r < 96) b = 8'($urandom_range(127, 255));
        else begin
            b = 8'($urandom_range(0, 31));
            if (b == 8'h08 || b == 8'h0A || b == 8'h0C || b == 8'h0D) b = 8'h07;
        end
        return b;
    endfunction

    initial begin
        int lowcnt;
        errs       = 0;
        checks     = 0;
        mx         = 0;
        my         = 0;
        cur_rdy    = 1'b1;
        rst        = 1'b1;
        char_valid = 1'b0;
        char_data  = 8'h00;

        // Reset values while reset is held.
        #1;
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_cursor_x", cursor_x, 0);
        chk("rst_cursor_y", cursor_y, 0);
        chk("rst_ready", char_ready, 1'b1);
        tick();
        tick();
        rst = 1'b0;

        // Single printable.
        send(8'h41);
        chk("A_addr", wr_addr, 0);
        chk("A_data", wr_data, 7'h21);
        chk("A_cursor_x", cursor_x, 1);

        // Fill the rest of row 0; last one wraps into a row-1 clear.
        for (int i = 0; i < C - 2; i++) send(8'h61 + 8'(i));
        send(8'h5A);
        chk("Z_addr", wr_addr, C - 1);
        chk("Z_data", wr_data, 7'h3A);
        chk("Z_cursor_x", cursor_x, 0);
        chk("Z_cursor_y", cursor_y, 1);
        lowcnt = 0;
        for (int g = 0; g < 100 && !char_ready; g++) begin
            lowcnt++;
            tick();
        end
        chk("Z_ready_low_cycles", lowcnt, C + 1);

        // LF from the last row wraps to row 0 and clears it.
        for (int i = 0; i < 5; i++) send(8'h62);
        send(8'h0A);
        chk("LF_addr", wr_addr, 0);
        chk("LF_cursor_y", cursor_y, 0);
        for (int i = 0; i < C; i++) tick();

        // BS / CR / ignored codes on row 1.
        send(8'h0A);
        for (int i = 0; i < C; i++) tick();
        send(8'h63); send(8'h64); send(8'h65);
        send(8'h08);
        chk("BS_addr", wr_addr, C + 2);
        chk("BS_data", wr_data, 0);
        chk("BS_cursor_x", cursor_x, 2);
        send(8'h0D);
        chk("CR_wr_en", wr_en, 1'b0);
        chk("CR_cursor_x", cursor_x, 0);
        send(8'h08);
        chk("BS0_wr_en", wr_en, 1'b0);
        chk("BS0_cursor_x", cursor_x, 0);
        send(8'h07);
        chk("BEL_wr_en", wr_en, 1'b0);
        chk("BEL_ready", char_ready, 1'b1);

        // FF with the next byte held waiting throughout the clear.
        send(8'h0C);
        send(8'h78);
        chk("FF_next_addr", wr_addr, 0);
        chk("FF_next_data", wr_data, 7'h58);
        chk("FF_next_cursor_x", cursor_x, 1);

        // Reset in the middle of a screen clear.
        send(8'h0C);
        for (int i = 0; i < 4; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_wr_en", wr_en, 1'b0);
        chk("midrst_wr_addr", wr_addr, 0);
        chk("midrst_cursor_x", cursor_x, 0);
        chk("midrst_cursor_y", cursor_y, 0);
        chk("midrst_ready", char_ready, 1'b1);
        q.delete();
        mx = 0;
        my = 0;
        tick();
        rst = 1'b0;
        send(8'h42);
        chk("B_addr", wr_addr, 0);
        chk("B_data", wr_data, 7'h22);

        // Random traffic with random gaps, including back-to-back bytes.
        for (int n = 0; n < 3000; n++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) tick();
            send(rand_byte());
        end
        for (int i = 0; i < C * R + 2; i++) tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/text_console_writer.md
# text_console_writer

Character-stream writer for the text-mode screen buffer that the LCD pixel generator scans. It accepts ASCII bytes over a valid/ready handshake (e.g. from a UART receiver), tracks a cursor, and issues single-port writes of 7-bit glyph indices into the screen memory. It interprets a small set of control codes, including newline, carriage return, backspace and form-feed, and performs row/screen clearing. Glyph index = ASCII − 0x20, matching the 95-entry font, 16 bytes per glyph.

## Interface
Parameters:
- CHAR_COLUMNS, 60, character columns (480 / 8); 8 for SIM builds.
- CHAR_ROWS, 17, character rows (272 / 16); 2 for SIM builds.
- ADDR_W, 10, screen memory address width; must satisfy 2^ADDR_W ≥ CHAR_COLUMNS·CHAR_ROWS.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- char_data  in  8  ASCII byte.
- char_valid  in  1  char_data valid; must be held stable until accepted.
- char_ready  out  1  block can accept; a byte is accepted on a clk edge where char_valid && char_ready.
- wr_en  out  1  screen memory write strobe, one write per cycle high.
- wr_addr  out  ADDR_W  write address = row·CHAR_COLUMNS + column.
- wr_data  out  7  glyph index written.
- cursor_x  out  7  current cursor column.
- cursor_y  out  5  current cursor row.

## Operation
- States: IDLE (char_ready=1), CLR_ROW, CLR_ALL (char_ready=0 in both).
- Byte decoding in IDLE, on accept:
  - 0x20–0x7E: write (char−0x20) at the cursor, then advance x.
  - Advance from x=CHAR_COLUMNS−1 wraps: x=0, then line advance.
  - 0x0A (LF): x=0, line advance; no character write.
  - 0x0D (CR): x=0; no write.
  - 0x08 (BS): if x>0, x←x−1 and write 0 (space) at the new position. If x=0, no change and no write; BS never moves to the previous row.
  - 0x0C (FF): cursor←(0,0) and enter CLR_ALL.
  - Any other byte (incl. ≥0x7F): consumed, no write, cursor unchanged.
- Line advance: y←y+1, or y←0 when y=CHAR_ROWS−1 (wrap, no scrolling). Then enter CLR_ROW for the new row, which writes 0 to all CHAR_COLUMNS cells of that row in ascending column order.
- CLR_ALL: writes 0 to addresses 0 … CHAR_COLUMNS·CHAR_ROWS−1 in ascending order, one per cycle.
- On clear completion, return to IDLE.
- Address arithmetic:
  - row·CHAR_COLUMNS + col, computed unsigned at ADDR_W width.
  - No address ever exceeds CHAR_COLUMNS·CHAR_ROWS−1.
  - Cursor never exceeds (CHAR_COLUMNS−1, CHAR_ROWS−1).
- Reset does not touch screen memory contents (initial screen image preserved).

## Timing
- Reset values:
  - wr_en=0, wr_addr=0, wr_data=0.
  - cursor_x=0, cursor_y=0.
  - state IDLE, so char_ready=1 while rst is high and after release.
- wr_en, wr_addr, wr_data, cursor_x and cursor_y are registered. char_ready is decoded from state only, with no combinational path from char_valid.
- For a byte accepted at edge N, the resulting outputs are as follows:
  - Printable, no wrap: write visible in cycle N+1. Cursor updated in N+1. char_ready stays 1, so back-to-back bytes give one write per cycle.
  - Printable at last column: character write in N+1. Cursor shows (0, next row) in N+1. Row-clear writes in N+2 … N+1+CHAR_COLUMNS. char_ready=0 during N+1 … N+1+CHAR_COLUMNS, and 1 from N+2+CHAR_COLUMNS.
  - LF: clear writes in N+1 … N+CHAR_COLUMNS. char_ready=1 again at N+CHAR_COLUMNS+1.
  - FF: clear writes in N+1 … N+CHAR_COLUMNS·CHAR_ROWS. char_ready=1 again at N+CHAR_COLUMNS·CHAR_ROWS+1.
  - CR, BS, ignored codes: at most one write (BS) in N+1; char_ready stays 1.
- wr_en is low in every cycle that is not listed above.
- Reset asserted mid-clear:
  - Outputs go to their reset values immediately (asynchronous), and no further writes occur.
  - The partially cleared memory is left as is.
  - char_ready=1 on the first edge after release.

## Test plan
- Reset, send 'A' (0x41) → one wr_en pulse in the next cycle, wr_addr=0, wr_data=0x21; cursor=(1,0); char_ready never drops.
- Send 60 bytes 'a'…: the 60th byte is 'Z' at (59,0) → write addr 59, data 0x3A; then 60 writes of 0 at addr 60…119; cursor=(0,1); char_ready low for exactly 61 cycles.
- Cursor at (5,16), send LF → 60 zero-writes at addr 0…59; cursor=(0,0); no write at row 16.
- Cursor (3,2): send BS → write 0 at addr 122, cursor=(2,2). Send CR → cursor=(0,2), no write. Send BS at x=0 → no write, cursor unchanged. Send 0x07 → no write, accepted in one cycle.
- Send FF → 1020 consecutive zero-writes at addr 0…1019; cursor=(0,0); char_ready=1 at N+1021; char_valid held high meanwhile is not accepted until then.
- Send FF, then assert rst after the 500th clear write → wr_en=0 immediately, cursor=(0,0); after release, 'B' is written at addr 0 with data 0x22.
